// File: rtl/fp_add_pipe.sv
// Five-stage pipelined floating-point adder/subtractor (unpack, align, add, normalise, pack)
// with valid/ready handshake; denormals flush to zero, round-to-nearest-even.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_sub,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [2:0]               out_flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;          // hidden bit + fraction + guard/round/sticky
    localparam int XW = EXP_W + 2;          // signed exponent with headroom both ways
    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic [MW-1:0]       M_ONE    = MW'(1);
    localparam logic signed [XW-1:0] X_ONE   = XW'(1);
    localparam logic signed [XW-1:0] X_ZERO  = '0;
    localparam logic signed [XW-1:0] X_MAX   = {2'b00, EXP_ONES};

    logic adv;
    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

    // ---------------- Stage 1: unpack ----------------
    logic [EXP_W-1:0] ea_in, eb_in;
    logic [MAN_W-1:0] fa_in, fb_in;
    assign ea_in = in_a[W-2:MAN_W];
    assign eb_in = in_b[W-2:MAN_W];
    assign fa_in = in_a[MAN_W-1:0];
    assign fb_in = in_b[MAN_W-1:0];

    logic             s1_valid, s1_sa, s1_sb, s1_nan, s1_inf_a, s1_inf_b;
    logic [TAG_W-1:0] s1_tag;
    logic [EXP_W-1:0] s1_ea, s1_eb;
    logic [MAN_W:0]   s1_ma, s1_mb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0; s1_tag <= '0; s1_sa <= 1'b0; s1_sb <= 1'b0;
            s1_ea <= '0; s1_eb <= '0; s1_ma <= '0; s1_mb <= '0;
            s1_nan <= 1'b0; s1_inf_a <= 1'b0; s1_inf_b <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_tag   <= in_tag;
            s1_sa    <= in_a[W-1];
            s1_sb    <= in_b[W-1] ^ in_sub;
            s1_ea    <= ea_in;
            s1_eb    <= eb_in;
            // A zero exponent field means zero: denormal fractions are dropped.
            s1_ma    <= (ea_in != '0) ? {1'b1, fa_in} : '0;
            s1_mb    <= (eb_in != '0) ? {1'b1, fb_in} : '0;
            s1_nan   <= ((ea_in == EXP_ONES) && (fa_in != '0)) ||
                        ((eb_in == EXP_ONES) && (fb_in != '0));
            s1_inf_a <= (ea_in == EXP_ONES) && (fa_in == '0);
            s1_inf_b <= (eb_in == EXP_ONES) && (fb_in == '0);
        end
    end

    // ---------------- Stage 2: align ----------------
    logic             swap, big_s;
    logic [EXP_W-1:0] big_e, sml_e, shamt;
    logic [MAN_W:0]   big_m, sml_m;
    logic [MW-1:0]    sml_ext, sml_mask, sml_aligned;

    always_comb begin
        swap     = {s1_eb, s1_mb} > {s1_ea, s1_ma};
        big_s    = swap ? s1_sb : s1_sa;
        big_e    = swap ? s1_eb : s1_ea;
        sml_e    = swap ? s1_ea : s1_eb;
        big_m    = swap ? s1_mb : s1_ma;
        sml_m    = swap ? s1_ma : s1_mb;
        shamt    = big_e - sml_e;
        sml_ext  = {sml_m, 3'b000};
        // Bits shifted past the sticky position collapse into it; huge shifts keep only sticky.
        sml_mask    = (M_ONE << shamt) - M_ONE;
        sml_aligned = (sml_ext >> shamt) | MW'(|(sml_ext & sml_mask));
    end

    logic             s2_valid, s2_sign, s2_sub, s2_nan, s2_inf, s2_inf_s;
    logic [TAG_W-1:0] s2_tag;
    logic [EXP_W-1:0] s2_exp;
    logic [MW-1:0]    s2_big, s2_sml;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0; s2_tag <= '0; s2_sign <= 1'b0; s2_sub <= 1'b0;
            s2_exp <= '0; s2_big <= '0; s2_sml <= '0;
            s2_nan <= 1'b0; s2_inf <= 1'b0; s2_inf_s <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_sign  <= big_s;
            s2_sub   <= s1_sa ^ s1_sb;
            s2_exp   <= big_e;
            s2_big   <= {big_m, 3'b000};
            s2_sml   <= sml_aligned;
            s2_nan   <= s1_nan | (s1_inf_a & s1_inf_b & (s1_sa ^ s1_sb));
            s2_inf   <= s1_inf_a | s1_inf_b;
            s2_inf_s <= s1_inf_a ? s1_sa : s1_sb;
        end
    end

    // ---------------- Stage 3: add ----------------
    logic             s3_valid, s3_sign, s3_same, s3_nan, s3_inf, s3_inf_s;
    logic [TAG_W-1:0] s3_tag;
    logic [EXP_W-1:0] s3_exp;
    logic [MW:0]      s3_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0; s3_tag <= '0; s3_sign <= 1'b0; s3_same <= 1'b0;
            s3_exp <= '0; s3_sum <= '0; s3_nan <= 1'b0; s3_inf <= 1'b0; s3_inf_s <= 1'b0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            s3_tag   <= s2_tag;
            s3_sign  <= s2_sign;
            s3_same  <= ~s2_sub;
            s3_exp   <= s2_exp;
            s3_sum   <= s2_sub ? ({1'b0, s2_big} - {1'b0, s2_sml})
                               : ({1'b0, s2_big} + {1'b0, s2_sml});
            s3_nan   <= s2_nan;
            s3_inf   <= s2_inf;
            s3_inf_s <= s2_inf_s;
        end
    end

    // ---------------- Stage 4: normalise ----------------
    logic [XW-1:0]        lz;
    logic signed [XW-1:0] exp_ext, nexp;
    logic [MW-1:0]        norm;
    logic                 sum_zero;

    always_comb begin
        lz = '0;
        for (int i = 0; i < MW; i++) begin
            if (s3_sum[i]) lz = XW'(MW - 1 - i);
        end
        exp_ext  = $signed({2'b00, s3_exp});
        sum_zero = (s3_sum == '0);
        if (s3_sum[MW]) begin
            norm = {s3_sum[MW:2], |s3_sum[1:0]};
            nexp = exp_ext + X_ONE;
        end else begin
            norm = s3_sum[MW-1:0] << lz;
            nexp = exp_ext - $signed(lz);
        end
    end

    logic                 s4_valid, s4_sign, s4_zero, s4_nan, s4_inf, s4_inf_s;
    logic [TAG_W-1:0]     s4_tag;
    logic signed [XW-1:0] s4_exp;
    logic [MW-1:0]        s4_mant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s4_valid <= 1'b0; s4_tag <= '0; s4_sign <= 1'b0; s4_zero <= 1'b0;
            s4_exp <= '0; s4_mant <= '0; s4_nan <= 1'b0; s4_inf <= 1'b0; s4_inf_s <= 1'b0;
        end else if (adv) begin
            s4_valid <= s3_valid;
            s4_tag   <= s3_tag;
            // Exact cancellation gives +0; only two like-signed zeros keep a negative sign.
            s4_sign  <= sum_zero ? (s3_same & s3_sign) : s3_sign;
            s4_zero  <= sum_zero;
            s4_exp   <= nexp;
            s4_mant  <= norm;
            s4_nan   <= s3_nan;
            s4_inf   <= s3_inf;
            s4_inf_s <= s3_inf_s;
        end
    end

    // ---------------- Stage 5: round and pack ----------------
    logic                 round_up;
    logic [MAN_W+1:0]     rnd;
    logic signed [XW-1:0] rexp;
    logic [MAN_W-1:0]     frac;
    logic [W-1:0]         res;
    logic [2:0]           flg;

    always_comb begin
        round_up = s4_mant[2] & (s4_mant[1] | s4_mant[0] | s4_mant[3]);
        rnd      = {1'b0, s4_mant[MW-1:3]} + (MAN_W+2)'(round_up);
        rexp     = s4_exp + (rnd[MAN_W+1] ? X_ONE : X_ZERO);
        frac     = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        res      = {s4_sign, rexp[EXP_W-1:0], frac};
        flg      = 3'b000;
        if (s4_nan) begin
            res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            flg = 3'b100;
        end else if (s4_inf) begin
            res = {s4_inf_s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s4_zero) begin
            res = {s4_sign, {(W-1){1'b0}}};
        end else if (rexp >= X_MAX) begin
            res = {s4_sign, EXP_ONES, {MAN_W{1'b0}}};
            flg = 3'b010;
        end else if (s4_exp <= X_ZERO) begin
            res = {s4_sign, {(W-1){1'b0}}};
            flg = 3'b001;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else if (adv) begin
            out_valid  <= s4_valid;
            out_result <= res;
            out_tag    <= s4_tag;
            out_flags  <= flg;
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed and streamed checks of fp_add_pipe in single precision, plus a half-precision instance.
module tb_fp_add_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  in_tag, out_tag;
    logic [2:0]  out_flags;

    logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
    logic [15:0] h_in_a, h_in_b, h_out_result;
    logic [3:0]  h_in_tag, h_out_tag;
    logic [2:0]  h_out_flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_flags(out_flags)
    );

    fp_add_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_result(h_out_result),
        .out_tag(h_out_tag), .out_flags(h_out_flags)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact sum in double precision, then round-to-nearest-even into single.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] bits;
        logic [10:0] fe;
        logic [30:0] mag;
        logic [28:0] rem;
        logic        up;
        if (r == 0.0) return 32'h0;
        bits = $realtobits(r);
        fe   = bits[62:52] - 11'd896;
        mag  = {fe[7:0], bits[51:29]};
        rem  = bits[28:0];
        up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && bits[29]);
        mag  = mag + 31'(up);
        return {bits[63], mag};
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 135)), 23'($urandom)};
    endfunction

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [3:0] tag,
                          input logic [31:0] exp_res, input logic [2:0] exp_flg);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_tag = tag; out_ready = 1'b1;
        #1;
        check_eq({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({name, "_latency"}, 32'(lat), 32'd5);
        check_eq({name, "_result"}, out_result, exp_res);
        check_eq({name, "_tag"}, 32'(out_tag), 32'(tag));
        check_eq({name, "_flags"}, 32'(out_flags), 32'(exp_flg));
        $display("op %s: %h %s %h -> %h flags %b tag %0d lat %0d",
                 name, a, sub ? "-" : "+", b, out_result, out_flags, out_tag, lat);
    endtask

    task automatic run_half(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_res, input logic [2:0] exp_flg);
        int lat;
        @(negedge clk);
        h_in_valid = 1'b1; h_in_a = a; h_in_b = b; h_in_sub = 1'b0; h_in_tag = 4'd9;
        @(negedge clk);
        h_in_valid = 1'b0;
        lat = 1;
        while (!h_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({name, "_latency"}, 32'(lat), 32'd5);
        check_eq({name, "_result"}, 32'(h_out_result), 32'(exp_res));
        check_eq({name, "_flags"}, 32'(h_out_flags), 32'(exp_flg));
        $display("half %s: %h + %h -> %h flags %b lat %0d", name, a, b, h_out_result, h_out_flags, lat);
    endtask

    logic [31:0] ra [20];
    logic [31:0] rb [20];
    logic        rs [20];
    logic [35:0] exp_q [$];

    initial begin
        int sent, got, c, stale, stalls;
        logic [35:0] e;

        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_sub = 1'b0; h_in_tag = '0; h_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_result", out_result, 32'd0);
        check_eq("rst_out_tag", 32'(out_tag), 32'd0);
        check_eq("rst_out_flags", 32'(out_flags), 32'd0);
        check_eq("rst_half_valid", 32'(h_out_valid), 32'd0);
        reset = 1'b0;

        // Directed single-precision vectors
        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 4'd3, 32'h40000000, 3'b000);
        run_op("exact_cancel", 32'h3FC00000, 32'h3FC00000, 1'b1, 4'd1, 32'h00000000, 3'b000);
        run_op("tie_to_even",  32'h3F800000, 32'h33800000, 1'b0, 4'd2, 32'h3F800000, 3'b000);
        run_op("inf_minus_inf",32'h7F800000, 32'hFF800000, 1'b0, 4'd4, 32'h7FC00000, 3'b100);
        run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd5, 32'h7F800000, 3'b010);
        run_op("underflow",    32'h00800000, 32'h00800001, 1'b1, 4'd6, 32'h80000000, 3'b001);
        run_op("denorm_flush", 32'h00400000, 32'h3F800000, 1'b0, 4'd7, 32'h3F800000, 3'b000);
        run_op("neg_zeros",    32'h80000000, 32'h80000000, 1'b0, 4'd8, 32'h80000000, 3'b000);
        run_op("three_minus_1",32'h40400000, 32'h3F800000, 1'b1, 4'd9, 32'h40000000, 3'b000);
        run_op("nan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 4'd10, 32'h7FC00000, 3'b100);
        run_op("inf_plus_one", 32'hFF800000, 32'h3F800000, 1'b0, 4'd11, 32'hFF800000, 3'b000);

        // Half-precision instance
        run_half("h_one_plus_one", 16'h3C00, 16'h3C00, 16'h4000, 3'b000);
        run_half("h_overflow",     16'h7BFF, 16'h7BFF, 16'h7C00, 3'b010);

        // Stream of 20 random pairs with a backpressure window
        for (int i = 0; i < 20; i++) begin
            ra[i] = rnd_f();
            rb[i] = rnd_f();
            rs[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; c = 0; stalls = 0;
        while (got < 20 && c < 300) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 20) begin
                in_valid = 1'b1; in_a = ra[sent]; in_b = rb[sent];
                in_sub = rs[sent]; in_tag = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream_extra", 32'(got), 32'd20);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("stream_result", out_result, e[31:0]);
                    check_eq("stream_tag", 32'(out_tag), 32'(e[35:32]));
                    $display("stream %0d: tag %0d result %h expected %h", got, out_tag, out_result, e[31:0]);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                e[31:0]  = r2f(f2r(in_a) + (in_sub ? -f2r(in_b) : f2r(in_b)));
                e[35:32] = in_tag;
                exp_q.push_back(e);
                sent++;
            end
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("stream_count", 32'(got), 32'd20);
        check_eq("stream_sent", 32'(sent), 32'd20);
        check_eq("stream_stalled", 32'(stalls > 0), 32'd1);

        // Reset with three operations held in the pipe by backpressure
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0; in_tag = 4'(12 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check_eq("pre_rst_in_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_eq("post_rst_stale", 32'(stale), 32'd0);
        run_op("after_reset", 32'h3F800000, 32'h40000000, 1'b0, 4'd15, 32'h40400000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
